// File: rtl/alu_seq_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer driving an external 8-bit ALU; owns PC and accumulator.
// Define ALU_SEQ_JZ_EN to turn opcode 000 into JZ and add the `zero` output.
module alu_seq_ctrl #(
    parameter int unsigned AW      = 5,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [7:0]    mem_rdata,
    output logic          EALU,
    output logic          IADD,
    output logic          ISUB,
    output logic          IAND,
    output logic          IOR,
    output logic [7:0]    alu_data,
    output logic [7:0]    accum,
    input  logic [7:0]    alu_out,
    output logic [AW-1:0] pc,
    output logic          busy,
`ifdef ALU_SEQ_JZ_EN
    output logic          zero,
`endif
    output logic          halted
);

    typedef enum logic [2:0] {
        StIdle,
        StFetchOp,
        StFetchArg,
        StExec,
        StWait,
        StWb,
        StHalt
    } state_e;

    typedef enum logic [2:0] {
        OpNop = 3'b000,
        OpAdd = 3'b001,
        OpSub = 3'b010,
        OpAnd = 3'b011,
        OpOr  = 3'b100,
        OpLda = 3'b101,
        OpJmp = 3'b110,
        OpHlt = 3'b111
    } op_e;

    // Number of WAIT cycles between EXEC and WB.
    localparam logic [2:0] WaitCycles = 3'(ALU_LAT - 1);

    state_e        state_q, state_d;
    op_e           op_q, op_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [7:0]    accum_q, accum_d;
    logic [7:0]    arg_q, arg_d;
    logic [2:0]    wait_q, wait_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= OpNop;
            pc_q    <= '0;
            accum_q <= 8'h00;
            arg_q   <= 8'h00;
            wait_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            pc_q    <= pc_d;
            accum_q <= accum_d;
            arg_q   <= arg_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        pc_d    = pc_q;
        accum_d = accum_q;
        arg_d   = arg_q;
        wait_d  = wait_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = StFetchOp;
                end
            end

            StFetchOp: begin
                if (mem_ack) begin
                    op_d    = op_e'(mem_rdata[7:5]);
                    pc_d    = pc_q + 1'b1;
                    state_d = StFetchArg;
                end
            end

            StFetchArg: begin
                if (mem_ack) begin
                    arg_d   = mem_rdata;
                    pc_d    = pc_q + 1'b1;
                    state_d = StFetchOp;
                    unique case (op_q)
                        OpNop: begin
`ifdef ALU_SEQ_JZ_EN
                            if (accum_q == 8'h00) begin
                                pc_d = mem_rdata[AW-1:0];
                            end
`endif
                        end
                        OpLda:   accum_d = mem_rdata;
                        OpJmp:   pc_d    = mem_rdata[AW-1:0];
                        OpHlt:   state_d = StHalt;
                        default: state_d = StExec;
                    endcase
                end
            end

            StExec: begin
                if (WaitCycles == 3'd0) begin
                    state_d = StWb;
                end else begin
                    wait_d  = WaitCycles - 3'd1;
                    state_d = StWait;
                end
            end

            StWait: begin
                if (wait_q == 3'd0) begin
                    state_d = StWb;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end

            StWb: begin
                accum_d = alu_out;
                state_d = StFetchOp;
            end

            StHalt: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = StFetchOp;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    logic fetching;
    logic exec;

    always_comb begin
        fetching = (state_q == StFetchOp) || (state_q == StFetchArg);
        exec     = (state_q == StExec);

        mem_req  = fetching;
        mem_addr = fetching ? pc_q : '0;

        EALU     = exec;
        IADD     = !(exec && (op_q == OpAdd));
        ISUB     = !(exec && (op_q == OpSub));
        IAND     = !(exec && (op_q == OpAnd));
        IOR      = !(exec && (op_q == OpOr));

        // Operand stays stable through WAIT so the ALU may sample it late.
        alu_data = arg_q;
        accum    = accum_q;
        pc       = pc_q;
        busy     = (state_q != StIdle) && (state_q != StHalt);
        halted   = (state_q == StHalt);
`ifdef ALU_SEQ_JZ_EN
        zero     = (accum_q == 8'h00);
`endif
    end

endmodule
